o2_monitor: RTL

O2_MONITOR -- requirements
Module: o2_monitor

---
 rtl/o2_pkg.sv | 35 +++
 rtl/o2_debounce.sv | 93 +++++++++
 rtl/o2_monitor.sv | 98 +++++++++
 3 files changed

// File: rtl/o2_pkg.sv
// Shared definitions for the O2 sensor mixture monitor: the 2-bit mixture
// state type, its four encodings, and small decode helpers.
package o2_pkg;

  typedef logic [1:0] o2_state_t;

  localparam o2_state_t ST_NORMAL = 2'b00;
  localparam o2_state_t ST_LEAN   = 2'b01;
  localparam o2_state_t ST_RICH   = 2'b10;
  localparam o2_state_t ST_FAULT  = 2'b11;

  // Reset level of the synchronized sensor pair; decodes to NORMAL.
  localparam logic SYNC_TOP_RST    = 1'b0;
  localparam logic SYNC_BOTTOM_RST = 1'b1;

  // Sensor pair to mixture state. Top high means lean, bottom low means
  // rich; both asserted at once is physically contradictory, so FAULT.
  function automatic o2_state_t decode_raw(input logic top, input logic bottom);
    o2_state_t st;
    case ({top, bottom})
      2'b01:   st = ST_NORMAL;
      2'b11:   st = ST_LEAN;
      2'b00:   st = ST_RICH;
      default: st = ST_FAULT;
    endcase
    return st;
  endfunction

  // Only a direct crossing between LEAN and RICH counts as a switch.
  function automatic logic is_switch(input o2_state_t from_st, input o2_state_t to_st);
    return ((from_st == ST_LEAN) && (to_st == ST_RICH)) ||
           ((from_st == ST_RICH) && (to_st == ST_LEAN));
  endfunction

endpackage

// File: rtl/o2_debounce.sv
// Synchronizes the two asynchronous sensor lines, filters the decoded
// mixture state and commits it once it has been stable for DEBOUNCE
// consecutive synchronized samples.
//
// Timing: the sensor pins are captured two edges later at the synchronizer
// output; the first differing sample loads the candidate and each further
// matching sample advances the filter. The edge carrying the DEBOUNCE-th
// matching sample commits, so a clean pin step reaches o2_state exactly
// DEBOUNCE+2 edges after it is applied.
//
// commit is combinational and is high in the cycle before o2_state changes,
// so the parent can update its dwell bookkeeping on the same edge.
// switch_pulse is registered and coincides with the new o2_state.
module o2_debounce
  import o2_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      o2_top,
  input  logic      o2_bottom,
  output o2_state_t o2_state,
  output logic      commit,
  output logic      switch_pulse
);

  // Filter count at which the next matching sample is the DEBOUNCE-th one.
  localparam logic [15:0] COMMIT_AT = 16'(DEBOUNCE - 2);

  logic        top_s1;
  logic        top_s2;
  logic        bottom_s1;
  logic        bottom_s2;
  o2_state_t   raw;
  o2_state_t   state_q;
  o2_state_t   cand_q;
  logic [15:0] filt_q;
  logic        switch_q;

  // Two-flop synchronizer per sensor line; reset level decodes to NORMAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_s1    <= SYNC_TOP_RST;
      top_s2    <= SYNC_TOP_RST;
      bottom_s1 <= SYNC_BOTTOM_RST;
      bottom_s2 <= SYNC_BOTTOM_RST;
    end else begin
      top_s1    <= o2_top;
      top_s2    <= top_s1;
      bottom_s1 <= o2_bottom;
      bottom_s2 <= bottom_s1;
    end
  end

  assign raw = decode_raw(top_s2, bottom_s2);

  // Commit when the candidate has filled the filter and is still present.
  assign commit = (raw != state_q) && (raw == cand_q) && (filt_q == COMMIT_AT);

  // Candidate filter: abandon on revert, restart on a new value, else count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      cand_q  <= ST_NORMAL;
      filt_q  <= '0;
    end else if (raw == state_q) begin
      cand_q <= state_q;
      filt_q <= '0;
    end else if (raw != cand_q) begin
      cand_q <= raw;
      filt_q <= '0;
    end else if (filt_q == COMMIT_AT) begin
      state_q <= cand_q;
      filt_q  <= '0;
    end else begin
      filt_q <= filt_q + 16'd1;
    end
  end

  // Strobe a LEAN<->RICH crossing in the cycle the new state appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_q <= 1'b0;
    end else begin
      switch_q <= commit && is_switch(state_q, cand_q);
    end
  end

  assign o2_state     = state_q;
  assign switch_pulse = switch_q;

endmodule

// File: rtl/o2_monitor.sv
// O2 sensor mixture monitor: debounced mixture state plus switch
// statistics, per-state dwell time and a stuck-sensor flag.
module o2_monitor
  import o2_pkg::*;
#(
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 30000000,
  parameter int DWELL_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               o2_top,
  input  logic               o2_bottom,
  input  logic               clr_stats,
  output logic [1:0]         o2_state,
  output logic               switch_pulse,
  output logic [15:0]        switch_count,
  output logic [DWELL_W-1:0] last_dwell,
  output logic               dwell_valid,
  output logic               stuck,
  output logic               fault
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] STUCK_AT  = DWELL_W'(TIMEOUT - 1);
  localparam logic [15:0]        SW_MAX    = 16'hffff;

  o2_state_t          state;
  logic               commit;
  logic               switch_strobe;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] last_dwell_q;
  logic               dwell_valid_q;
  logic [15:0]        sw_cnt_q;
  logic               stuck_q;

  o2_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .o2_top       (o2_top),
    .o2_bottom    (o2_bottom),
    .o2_state     (state),
    .commit       (commit),
    .switch_pulse (switch_strobe)
  );

  // Dwell time in the current state; captured (+1 for the commit cycle
  // itself) and restarted on every commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q       <= '0;
      last_dwell_q  <= '0;
      dwell_valid_q <= 1'b0;
    end else begin
      dwell_valid_q <= commit;
      if (commit) begin
        last_dwell_q <= (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + DWELL_ONE;
        dwell_q      <= '0;
      end else if (dwell_q != DWELL_MAX) begin
        dwell_q <= dwell_q + DWELL_ONE;
      end
    end
  end

  // Saturating switch counter; a clear overrides a coincident switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_q <= '0;
    end else if (clr_stats) begin
      sw_cnt_q <= '0;
    end else if (switch_strobe && (sw_cnt_q != SW_MAX)) begin
      sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  // Sticky stuck flag; a commit clears it even on the cycle it would set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= 1'b0;
    end else if (commit || clr_stats) begin
      stuck_q <= 1'b0;
    end else if (dwell_q == STUCK_AT) begin
      stuck_q <= 1'b1;
    end
  end

  assign o2_state     = state;
  assign switch_pulse = switch_strobe;
  assign switch_count = sw_cnt_q;
  assign last_dwell   = last_dwell_q;
  assign dwell_valid  = dwell_valid_q;
  assign stuck        = stuck_q;
  assign fault        = (state == ST_FAULT);

endmodule
